// File: rtl/dac_spi_writer_if.sv
`default_nettype none
// ============================================================================
// Module  : dac_spi_writer_if
// Brief   : Point handshake between the line-draw controller and the DAC writer.
// Revision: 1.0
// ============================================================================
interface dac_spi_writer_if;
  logic [11:0] x;
  logic [11:0] y;
  logic        valid;
  logic        ready;

  modport master (output x, output y, output valid, input ready);
  modport slave  (input x, input y, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/dac_spi_writer.sv
`default_nettype none
// ============================================================================
// Module  : dac_spi_writer
// Brief   : Shifts one (x,y) point into a dual 12-bit SPI DAC, then pulses LDAC.
// Revision: 1.0
// ============================================================================
module dac_spi_writer #(
  parameter int CLK_DIV     = 1,
  parameter int CS_GAP      = 2,
  parameter int LDAC_CYCLES = 1,
  parameter bit BUF_BIT     = 1'b0,
  parameter bit GAIN_1X     = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dac_spi_writer_if.slave  bus,
  output logic             cs_pin,
  output logic             clk_pin,
  output logic             data_pin,
  output logic             ldac_pin
);

  localparam int c_cnt_max = (CS_GAP > LDAC_CYCLES) ? CS_GAP : LDAC_CYCLES;
  localparam int c_cw      = $clog2(c_cnt_max + 1);
  localparam int c_dw      = $clog2(CLK_DIV + 1);

  localparam logic [c_dw-1:0] c_div_last  = c_dw'(CLK_DIV - 1);
  localparam logic [c_cw-1:0] c_gap_last  = c_cw'(CS_GAP - 1);
  localparam logic [c_cw-1:0] c_ldac_last = c_cw'(LDAC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT_A = 3'd1,
    S_GAP_A   = 3'd2,
    S_SHIFT_B = 3'd3,
    S_GAP_B   = 3'd4,
    S_LATCH   = 3'd5
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_ldac, w_ldac_nxt;
  logic [15:0]       r_sreg, w_sreg_nxt;
  logic [11:0]       r_y, w_y_nxt;
  logic [c_dw-1:0]   r_div, w_div_nxt;
  logic [3:0]        r_bit, w_bit_nxt;
  logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
  logic [15:0]       w_word_a, w_word_b;

  assign w_word_a = {1'b0, BUF_BIT, GAIN_1X, 1'b1, bus.x};
  assign w_word_b = {1'b1, BUF_BIT, GAIN_1X, 1'b1, r_y};

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_cs_nxt    = r_cs;
    w_sclk_nxt  = r_sclk;
    w_ldac_nxt  = r_ldac;
    w_sreg_nxt  = r_sreg;
    w_y_nxt     = r_y;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (r_ready && bus.valid) begin
          w_state_nxt = S_SHIFT_A;
          w_ready_nxt = 1'b0;
          w_cs_nxt    = 1'b0;
          w_sreg_nxt  = w_word_a;
          w_y_nxt     = bus.y;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end
      end
      S_SHIFT_A, S_SHIFT_B: begin
        if (r_div == c_div_last) begin
          w_div_nxt = '0;
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            // Data moves only on the falling edge; the final shift drains the register to zero.
            w_sclk_nxt = 1'b0;
            w_sreg_nxt = {r_sreg[14:0], 1'b0};
            w_bit_nxt  = r_bit + 4'd1;
            if (r_bit == 4'd15) begin
              w_cs_nxt    = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = (r_state == S_SHIFT_A) ? S_GAP_A : S_GAP_B;
            end
          end
        end else begin
          w_div_nxt = r_div + c_dw'(1);
        end
      end
      S_GAP_A: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = S_SHIFT_B;
          w_cs_nxt    = 1'b0;
          w_sreg_nxt  = w_word_b;
          w_div_nxt   = '0;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cw'(1);
        end
      end
      S_GAP_B: begin
        if (r_cnt == c_gap_last) begin
          w_state_nxt = S_LATCH;
          w_ldac_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cw'(1);
        end
      end
      S_LATCH: begin
        if (r_cnt == c_ldac_last) begin
          w_state_nxt = S_IDLE;
          w_ldac_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cw'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cs_nxt    = 1'b1;
        w_sclk_nxt  = 1'b0;
        w_ldac_nxt  = 1'b1;
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_ldac  <= 1'b1;
      r_sreg  <= '0;
      r_y     <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_cs    <= w_cs_nxt;
      r_sclk  <= w_sclk_nxt;
      r_ldac  <= w_ldac_nxt;
      r_sreg  <= w_sreg_nxt;
      r_y     <= w_y_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bus.ready = r_ready;
  assign cs_pin    = r_cs;
  assign clk_pin   = r_sclk;
  assign data_pin  = r_sreg[15];
  assign ldac_pin  = r_ldac;

endmodule
`default_nettype wire
